// File: rtl/mpu_regs_pkg.sv
// Register map constants and read-sequencer state encoding shared by the
// MPU9250 read and write side blocks.
package mpu_regs_pkg;

    localparam logic [7:0] MPU_READ_BIT     = 8'h80;
    localparam logic [7:0] MPU_ACCEL_XOUT_H = 8'h3B;
    localparam int         MPU_BURST_LEN    = 14;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_WAIT  = WAIT,
        S_NEXT  = NEXT,
        S_DONE  = DONE
    } rd_state_t;

    function automatic logic [7:0] mpu_read_addr(input logic [7:0] reg_addr);
        return MPU_READ_BIT | reg_addr;
    endfunction

endpackage

// File: rtl/mpu_burst_reader_rate_tick.sv
// Enable-gated free-running counter; tick is high in the cycle the count
// wraps from all-ones back to zero.
module mpu_rate_tick #(
    parameter int RATE_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    logic [RATE_BITS-1:0] rate_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_cnt <= '0;
        end else if (!enable) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= rate_cnt + RATE_BITS'(1);
        end
    end

    assign tick = enable && (rate_cnt == '1);

endmodule

// File: rtl/mpu_burst_reader.sv
// Burst sequencer in front of the single-byte MPU9250 SPI read engine:
// reads the 14 accel/temp/gyro registers and publishes seven words at once.
//
// state | meaning
// IDLE  | waiting for trigger or rate tick
// ISSUE | waiting for the byte engine to go idle, then start one byte read
// WAIT  | byte read in flight, watchdog running
// NEXT  | advance to next byte or finish the frame
// DONE  | words published this cycle, valid high
module mpu_burst_reader
    import mpu_regs_pkg::*;
#(
    parameter logic [7:0] BASE_REG     = MPU_ACCEL_XOUT_H,
    parameter int         NUM_BYTES    = MPU_BURST_LEN,
    parameter int         RATE_BITS    = 16,
    parameter int         TIMEOUT_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        trigger,
    input  logic        spi_busy,
    input  logic        spi_finish,
    input  logic [7:0]  spi_data,
    output logic        spi_start,
    output logic [7:0]  spi_addr,
    output logic [15:0] ax,
    output logic [15:0] ay,
    output logic [15:0] az,
    output logic [15:0] temp,
    output logic [15:0] gx,
    output logic [15:0] gy,
    output logic [15:0] gz,
    output logic        valid,
    output logic        active,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0]        IDX_ONE  = IDX_W'(1);
    localparam logic [TIMEOUT_BITS-1:0] WD_ONE   = TIMEOUT_BITS'(1);
    // Expire on the increment that makes the watchdog all-ones.
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST  = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    rd_state_t               state;
    logic [IDX_W-1:0]        idx;
    logic [TIMEOUT_BITS-1:0] wdog;
    logic [7:0]              byte_buf [NUM_BYTES];
    logic                    rate_tick;
    logic                    start_req;

    mpu_rate_tick #(
        .RATE_BITS (RATE_BITS)
    ) u_rate_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (rate_tick)
    );

    assign start_req = trigger || (enable && rate_tick);

    // Data-only storage; contents are meaningless until a frame completes.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && spi_finish) begin
            byte_buf[idx] <= spi_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            wdog        <= '0;
            spi_start   <= 1'b0;
            spi_addr    <= 8'h00;
            ax          <= 16'h0000;
            ay          <= 16'h0000;
            az          <= 16'h0000;
            temp        <= 16'h0000;
            gx          <= 16'h0000;
            gy          <= 16'h0000;
            gz          <= 16'h0000;
            valid       <= 1'b0;
            active      <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            valid     <= 1'b0;

            if (start_req && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        idx    <= '0;
                        active <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (!spi_busy) begin
                        spi_addr  <= mpu_read_addr(BASE_REG + 8'(idx));
                        spi_start <= 1'b1;
                        wdog      <= '0;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    wdog <= wdog + WD_ONE;
                    if (spi_finish) begin
                        state <= S_NEXT;
                    end else if (wdog == WD_LAST) begin
                        timeout_err <= 1'b1;
                        active      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        ax          <= {byte_buf[0],  byte_buf[1]};
                        ay          <= {byte_buf[2],  byte_buf[3]};
                        az          <= {byte_buf[4],  byte_buf[5]};
                        temp        <= {byte_buf[6],  byte_buf[7]};
                        gx          <= {byte_buf[8],  byte_buf[9]};
                        gy          <= {byte_buf[10], byte_buf[11]};
                        gz          <= {byte_buf[12], byte_buf[13]};
                        valid       <= 1'b1;
                        timeout_err <= 1'b0;
                        active      <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mpu_burst_reader.md
Name: mpu_burst_reader

Overview:
- Sequencer directly upstream of the single-byte MPU9250 SPI read engine; drives its start/addr and consumes its finish/data.
- Each frame reads the 14 consecutive sensor registers 0x3B..0x48: accel XYZ, temperature, gyro XYZ.
- Assembles the bytes into seven signed 16-bit words and publishes them atomically with a one-cycle valid pulse.
- Frames start on an external trigger pulse or on an internal rate tick.

Parameters:
- BASE_REG, 8'h3B, first register of the burst.
- NUM_BYTES, 14, bytes per frame; fixed by the output set and must stay even.
- RATE_BITS, 16, width of the internal frame-rate counter; a tick occurs when it wraps from all-ones to 0.
- TIMEOUT_BITS, 12, width of the per-byte watchdog counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  allows rate ticks to start frames; trigger works regardless
- trigger  in  1  one-cycle request to start a frame
- spi_busy  in  1  busy from the byte read engine
- spi_finish  in  1  one-cycle done pulse from the byte read engine
- spi_data  in  8  byte returned by the byte read engine
- spi_start  out  1  one-cycle start pulse to the byte read engine
- spi_addr  out  8  register address with the read bit set
- ax, ay, az  out  16  accel words, each {H,L}
- temp  out  16  temperature word
- gx, gy, gz  out  16  gyro words
- valid  out  1  one-cycle pulse when the seven words update
- active  out  1  high while a frame is in progress
- overrun  out  1  sticky; set when a start request arrives while active
- timeout_err  out  1  set on watchdog expiry; cleared by the next completed frame

Behaviour:
- Reset (async): all outputs 0, state IDLE, byte index 0, rate counter 0, watchdog 0.
- Start request = trigger OR (enable AND rate tick). The rate counter free-runs only while enable is high and clears when enable is low.
- IDLE:
  - On a start request, go to ISSUE; index=0, active=1.
- ISSUE:
  - Hold until spi_busy=0.
  - Then drive spi_addr = 8'h80 | (BASE_REG + index) and pulse spi_start=1 for exactly one cycle.
  - spi_addr is registered and stays stable from this cycle until finish.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On spi_finish: capture spi_data into byte buffer[index]; go to NEXT.
  - If the watchdog reaches all-ones first: set timeout_err=1, discard the partial frame (outputs unchanged, no valid), go to IDLE, active=0.
- NEXT:
  - If index == NUM_BYTES-1: go to DONE.
  - Otherwise index+1 and go to ISSUE.
- DONE:
  - Load all seven outputs from the buffer in a single cycle: word k = {buffer[2k], buffer[2k+1]}. Even index is the high byte.
  - Same cycle: valid=1, timeout_err=0, active=0; go to IDLE.
- Latency: the first spi_start comes 2 cycles after the start request, given spi_busy=0. valid comes 2 cycles after the 14th spi_finish.
- Start request while not in IDLE: the request is ignored and overrun is set (sticky until reset). A request in the DONE cycle also counts as overrun.
- trigger and a rate tick in the same cycle start a single frame.
- spi_finish outside WAIT is ignored.
- Outputs hold their last good values between frames.
- Deasserting enable mid-frame does not abort the frame.
- Reset mid-frame returns to IDLE immediately. No valid is produced, and outputs clear to 0.

Decomposition:
- Shared package mpu_regs_pkg holds the following constants, shared with the write-side blocks:
  - MPU_READ_BIT = 8'h80
  - MPU_ACCEL_XOUT_H = 8'h3B
  - MPU_BURST_LEN = 14
  - state encoding localparams IDLE/ISSUE/WAIT/NEXT/DONE
- One natural sub-module: mpu_rate_tick, the enable-gated wrapping counter that emits the one-cycle tick.
- The byte buffer and FSM stay in the top module.

Test Plan:
- Single frame: trigger with a model returning bytes 0x01..0x0E, busy low, finish 20 cycles after each start. Expect 14 starts with addresses 0xBB..0xC8 in order, then ax=0x0102, ay=0x0304, az=0x0506, temp=0x0708, gx=0x090A, gy=0x0B0C, gz=0x0D0E, one valid pulse, active low afterwards.
- Busy gating: hold spi_busy=1 for 50 cycles after trigger. Expect no spi_start until busy drops, then the first start the next cycle.
- Timeout: model never finishes byte 5 (TIMEOUT_BITS=4). Expect timeout_err=1 after 15 cycles in WAIT, no valid, outputs unchanged. A following good frame clears timeout_err and pulses valid.
- Overrun/simultaneous: trigger mid-frame. Expect overrun=1 and exactly one valid per frame. trigger and tick in the same cycle give exactly one frame.
- Rate ticks: enable=1, RATE_BITS=6. Expect frames starting every 64 cycles. Drop enable mid-frame: the frame completes and no further frames start.
- Async reset at byte 7: all outputs go to 0 immediately, with no clock edge needed. No valid follows. The next trigger yields a correct full frame.
